// File: rtl/addsub_arb_pkg.sv
// addsub_arb_pkg: shared constants and types for the add/sub arbiter.
//   ADDSUB_ARB_W_DEF : default operand/result width
//   op_e             : operation encoding carried on req_sub (OP_ADD / OP_SUB)
//   id_width()       : width of a requester index for n requesters
package addsub_arb_pkg;

    localparam int ADDSUB_ARB_W_DEF = 36;

    typedef enum logic {
        OP_ADD = 1'b0,
        OP_SUB = 1'b1
    } op_e;

    function automatic int id_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/addsub_arb_rr.sv
// addsub_arb_rr: round-robin picker.
//   req : request vector, one bit per requester
//   ptr : index where the search starts (highest priority this cycle)
//   en  : when low, nothing is granted
//   gnt : one-hot grant (all zero when nothing granted)
//   idx : index of the granted requester (0 when nothing granted)
module addsub_arb_rr
    import addsub_arb_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IW   = id_width(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   ptr,
    input  logic            en,
    output logic [NREQ-1:0] gnt,
    output logic [IW-1:0]   idx
);

    logic found;
    int   j;

    // Walk the requesters starting at ptr, wrapping once; first hit wins.
    always_comb begin
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        j     = 0;
        for (int k = 0; k < NREQ; k++) begin
            j = int'(ptr) + k;
            if (j >= NREQ) j = j - NREQ;
            if (en && !found && req[j]) begin
                found  = 1'b1;
                gnt[j] = 1'b1;
                idx    = IW'(j);
            end
        end
    end

endmodule

// File: rtl/addsub_arbiter.sv
// addsub_arbiter: NREQ requesters share one W-bit adder/subtractor through a
// round-robin arbiter; the result sits in a single output register.
//   clk, reset          : clock, synchronous active-high reset
//   req_valid/req_ready : per-requester handshake (accepted on valid & ready)
//   req_a, req_b        : packed operands, requester i at [i*W +: W]
//   req_sub             : per-requester op, 1 = A-B, 0 = A+B
//   rsp_valid/rsp_ready : result handshake
//   rsp_data, rsp_id    : result and the index of the requester that owns it
//   rsp_ovf             : only with ADDSUB_ARB_OVF_EN defined; carry-out for
//                         add, borrow (unsigned A<B) for subtract
module addsub_arbiter
    import addsub_arb_pkg::*;
#(
    parameter  int NREQ = 4,
    parameter  int W    = ADDSUB_ARB_W_DEF,
    localparam int IW   = id_width(NREQ)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [NREQ*W-1:0] req_a,
    input  logic [NREQ*W-1:0] req_b,
    input  logic [NREQ-1:0]   req_sub,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [W-1:0]      rsp_data,
`ifdef ADDSUB_ARB_OVF_EN
    output logic              rsp_ovf,
`endif
    output logic [IW-1:0]     rsp_id
);

    logic [NREQ-1:0][W-1:0] a_arr, b_arr;
    logic [IW-1:0]          ptr, ptr_nxt, idx;
    logic [NREQ-1:0]        gnt;
    logic                   can_accept, any_gnt, is_sub;
    logic [W-1:0]           a_sel, b_op, sum;

    assign a_arr = req_a;
    assign b_arr = req_b;

    // Result register can take a new value when empty or draining this cycle.
    assign can_accept = !reset && (!rsp_valid || rsp_ready);

    addsub_arb_rr #(.NREQ(NREQ), .IW(IW)) u_rr (
        .req (req_valid),
        .ptr (ptr),
        .en  (can_accept),
        .gnt (gnt),
        .idx (idx)
    );

    assign req_ready = gnt;
    assign any_gnt   = |gnt;
    assign ptr_nxt   = (idx == IW'(NREQ - 1)) ? '0 : idx + 1'b1;

    // Shared adder: subtract is A + ~B + 1, the +1 riding in as carry-in.
    assign is_sub = (req_sub[idx] == OP_SUB);
    assign a_sel  = a_arr[idx];
    assign b_op   = is_sub ? ~b_arr[idx] : b_arr[idx];

`ifdef ADDSUB_ARB_OVF_EN
    logic [W:0] sum_ext;
    logic       ovf_nxt;
    assign sum_ext = {1'b0, a_sel} + {1'b0, b_op} + {{W{1'b0}}, is_sub};
    assign sum     = sum_ext[W-1:0];
    // For subtract the carry-out means "no borrow", so invert it.
    assign ovf_nxt = is_sub ? ~sum_ext[W] : sum_ext[W];
`else
    assign sum = a_sel + b_op + {{(W-1){1'b0}}, is_sub};
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_id    <= '0;
            ptr       <= '0;
`ifdef ADDSUB_ARB_OVF_EN
            rsp_ovf   <= 1'b0;
`endif
        end else if (any_gnt) begin
            rsp_valid <= 1'b1;
            rsp_data  <= sum;
            rsp_id    <= idx;
            ptr       <= ptr_nxt;
`ifdef ADDSUB_ARB_OVF_EN
            rsp_ovf   <= ovf_nxt;
`endif
        end else if (rsp_ready) begin
            rsp_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_addsub_arbiter.sv
// tb_addsub_arbiter: directed scoreboard bench for addsub_arbiter (NREQ=4,
// W=36). Stimulus pushes hand-computed results into a queue; a monitor pops
// and compares on each rsp_valid & rsp_ready handshake.
module tb_addsub_arbiter;

    localparam int NREQ = 4;
    localparam int W    = 36;

    typedef struct {
        int          id;
        logic [W-1:0] data;
        logic        ovf;
    } exp_t;

    logic              clk = 1'b0;
    logic              reset;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ*W-1:0] req_a;
    logic [NREQ*W-1:0] req_b;
    logic [NREQ-1:0]   req_sub;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [W-1:0]      rsp_data;
    logic [1:0]        rsp_id;
`ifdef ADDSUB_ARB_OVF_EN
    logic              rsp_ovf;
`endif

    int   total = 0;
    int   bad   = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    addsub_arbiter #(.NREQ(NREQ), .W(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_sub   (req_sub),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
`ifdef ADDSUB_ARB_OVF_EN
        .rsp_ovf   (rsp_ovf),
`endif
        .rsp_id    (rsp_id)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic neg;
        @(negedge clk);
    endtask

    task automatic set_req(input int i, input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
        req_a[i*W +: W] = a;
        req_b[i*W +: W] = b;
        req_sub[i]      = s;
    endtask

    task automatic push(input int id, input logic [W-1:0] d, input logic o);
        exp_t e;
        e.id   = id;
        e.data = d;
        e.ovf  = o;
        sb.push_back(e);
    endtask

    // Monitor: every consumed result must match the oldest expectation.
    always @(negedge clk) begin
        if (!reset && rsp_valid && rsp_ready) begin
            if (sb.size() == 0) begin
                chk("unexpected_rsp", 64'(rsp_id), 64'hdead);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("rsp_id", 64'(rsp_id), 64'(e.id));
                chk("rsp_data", 64'(rsp_data), 64'(e.data));
`ifdef ADDSUB_ARB_OVF_EN
                chk("rsp_ovf", 64'(rsp_ovf), 64'(e.ovf));
`endif
            end
        end
    end

    initial begin
        reset     = 1'b1;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        req_sub   = '0;
        rsp_ready = 1'b1;

        // Reset: requests present but nothing granted, outputs cleared.
        req_valid = 4'b1111;
        tick; tick;
        neg;
        chk("reset_ready", 64'(req_ready), 64'h0);
        chk("reset_valid", 64'(rsp_valid), 64'h0);
        chk("reset_data",  64'(rsp_data),  64'h0);
        chk("reset_id",    64'(rsp_id),    64'h0);
        tick;
        reset     = 1'b0;
        req_valid = '0;
        tick;

        // Fairness: all valid, grants 0,1,2,3,0 back to back.
        for (int i = 0; i < NREQ; i++)
            set_req(i, 36'h100 * (i + 1), 36'(i + 1), 1'b0);
        req_valid = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            push(k % 4, 36'h101 * ((k % 4) + 1), 1'b0);
            neg;
            chk("fair_ready", 64'(req_ready), 64'(4'b0001 << (k % 4)));
            if (k > 0) chk("fair_stream", 64'(rsp_valid), 64'h1);
            tick;
        end
        req_valid = '0;
        tick;                                  // P = 1

        // Single subtract on requester 0: 5 - 3 = 2.
        set_req(0, 36'h5, 36'h3, 1'b1);
        req_valid = 4'b0001;
        push(0, 36'h2, 1'b0);
        neg;
        chk("single_ready", 64'(req_ready), 64'h1);
        tick;
        req_valid = '0;
        neg;
        chk("single_latency", 64'(rsp_valid), 64'h1);
        tick;                                  // P = 1

        // Wrap on add: all-ones + 1 = 0 with carry.
        set_req(1, 36'hF_FFFF_FFFF, 36'h1, 1'b0);
        req_valid = 4'b0010;
        push(1, 36'h0, 1'b1);
        neg;
        chk("wrap_add_ready", 64'(req_ready), 64'h2);
        tick;                                  // P = 2

        // Wrap on subtract: 0 - 1 = all-ones with borrow (refill while draining).
        set_req(2, 36'h0, 36'h1, 1'b1);
        req_valid = 4'b0100;
        push(2, 36'hF_FFFF_FFFF, 1'b1);
        neg;
        chk("wrap_sub_ready", 64'(req_ready), 64'h4);
        tick;                                  // P = 3
        req_valid = '0;
        tick;

        // Move P to 2: search 3,0,1 picks requester 1.
        set_req(1, 36'd10, 36'd20, 1'b0);
        req_valid = 4'b0010;
        push(1, 36'd30, 1'b0);
        neg;
        chk("ptr_setup_ready", 64'(req_ready), 64'h2);
        tick;                                  // P = 2

        // Pointer: 1 and 3 valid with P=2 -> 3 first, then 1.
        set_req(1, 36'd100, 36'd1, 1'b1);
        set_req(3, 36'd7, 36'd8, 1'b0);
        req_valid = 4'b1010;
        push(3, 36'd15, 1'b0);
        neg;
        chk("ptr_first", 64'(req_ready), 64'h8);
        tick;                                  // P = 0
        req_valid = 4'b0010;
        push(1, 36'd99, 1'b0);
        neg;
        chk("ptr_second", 64'(req_ready), 64'h2);
        tick;                                  // P = 2
        req_valid = '0;
        tick;

        // Backpressure: result held 5 cycles, no grants, then drain+refill.
        set_req(0, 36'd50, 36'd8, 1'b1);
        req_valid = 4'b0001;
        rsp_ready = 1'b0;
        push(0, 36'd42, 1'b0);
        tick;                                  // grant 0, P = 1
        set_req(2, 36'd1, 36'd1, 1'b0);
        req_valid = 4'b0100;
        for (int k = 0; k < 5; k++) begin
            neg;
            chk("bp_ready", 64'(req_ready), 64'h0);
            chk("bp_valid", 64'(rsp_valid), 64'h1);
            chk("bp_data",  64'(rsp_data),  64'd42);
            chk("bp_id",    64'(rsp_id),    64'h0);
            tick;
        end
        rsp_ready = 1'b1;
        push(2, 36'd2, 1'b0);
        neg;
        chk("bp_refill_ready", 64'(req_ready), 64'h4);
        tick;                                  // P = 3
        req_valid = '0;
        tick;

        // Reset mid-flow: the pending result is discarded, P returns to 0.
        set_req(3, 36'd9, 36'd4, 1'b1);
        req_valid = 4'b1000;
        rsp_ready = 1'b0;
        tick;
        req_valid = '0;
        neg;
        chk("mid_pre_valid", 64'(rsp_valid), 64'h1);
        tick;
        reset = 1'b1;
        tick;
        neg;
        chk("mid_rst_valid", 64'(rsp_valid), 64'h0);
        chk("mid_rst_data",  64'(rsp_data),  64'h0);
        tick;
        reset     = 1'b0;
        rsp_ready = 1'b1;
        req_valid = 4'b1010;
        push(1, 36'd99, 1'b0);
        neg;
        chk("post_rst_first", 64'(req_ready), 64'h2);
        tick;                                  // P = 2
        req_valid = 4'b1000;
        push(3, 36'd5, 1'b0);
        neg;
        chk("post_rst_second", 64'(req_ready), 64'h8);
        tick;
        req_valid = '0;
        tick; tick;

        chk("sb_empty", 64'(sb.size()), 64'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/addsub_arbiter.md
ADDSUB_ARBITER -- requirements
Module: addsub_arbiter

Interface
REQ-001 SHALL have parameter NREQ, default 4: number of requesters, legal range 2..16.
REQ-002 SHALL have parameter W, default 36: operand and result width.
REQ-003 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port req_valid, input, NREQ: per-requester operation request.
REQ-006 SHALL have port req_ready, output, NREQ: per-requester grant; an op is accepted when valid&ready in the same cycle.
REQ-007 SHALL have port req_a, input, NREQ*W: operand A, requester i in bits [i*W +: W].
REQ-008 SHALL have port req_b, input, NREQ*W: operand B, same packing.
REQ-009 SHALL have port req_sub, input, NREQ: 1 = A-B, 0 = A+B.
REQ-010 SHALL have port rsp_valid, output, 1: result register holds a result.
REQ-011 SHALL have port rsp_ready, input, 1: consumer accepts the result.
REQ-012 SHALL have port rsp_data, output, W: result.
REQ-013 SHALL have port rsp_id, output, clog2(NREQ): index of the requester that owns rsp_data.

Function
REQ-014 SHALL compute A+B mod 2^W for add, and A+~B+1 mod 2^W for subtract, on one shared adder.
REQ-015 SHALL assert at most one req_ready bit per cycle, and only for a requester whose req_valid is 1.
REQ-016 SHALL grant only when the result register is empty, or is full with rsp_ready=1 in the same cycle (drain-and-refill, no bubble).
REQ-017 SHALL pick round-robin: search begins at pointer P; after a grant to i, P becomes (i+1) mod NREQ; with no grant, P is unchanged.
REQ-018 SHALL register the result: rsp_valid=1 and rsp_data/rsp_id valid the cycle after acceptance (latency 1).
REQ-019 SHALL hold rsp_data and rsp_id stable while rsp_valid=1 and rsp_ready=0.
REQ-020 SHALL clear rsp_valid after a cycle with rsp_valid&rsp_ready and no new grant.
REQ-021 SHALL require each requester to hold req_valid and its operands stable until it is granted; the block does not tolerate a withdrawn request.
REQ-022 SHALL drive req_ready combinationally from req_valid, P and the result-register state; req_ready SHALL NOT depend on operand values.

Reset
REQ-023 SHALL, on reset, set rsp_valid=0, rsp_data=0, rsp_id=0 and P=0, with req_ready=0 throughout reset cycles.
REQ-024 SHALL discard any result not yet consumed when reset is asserted mid-operation; there is no partial-state recovery.

Configuration
REQ-025 SHALL, when ADDSUB_ARB_OVF_EN is defined, add output rsp_ovf (1 bit, registered alongside rsp_data, reset 0): carry-out for add, borrow (unsigned A<B) for subtract.
REQ-026 SHALL, when ADDSUB_ARB_OVF_EN is undefined, omit the rsp_ovf port and its logic; all other behaviour is identical.

Structure
REQ-027 SHALL place the default width constant, the op encoding (OP_ADD=0, OP_SUB=1) and the id-width function in shared package addsub_arb_pkg.
REQ-028 SHALL implement the round-robin picker as sub-module addsub_arb_rr (inputs: request vector, pointer, enable; outputs: one-hot grant and index).

Verification
REQ-029 Single op: req0 A=36'h0_0000_0005, B=3, sub=1 -> next cycle rsp_valid=1, rsp_data=2, rsp_id=0.
REQ-030 Wrap/overflow: A=36'hF_FFFF_FFFF, B=1, add -> rsp_data=0 (rsp_ovf=1 with the macro); A=0, B=1, sub -> rsp_data=36'hF_FFFF_FFFF (rsp_ovf=1).
REQ-031 Fairness: all 4 requesters held valid, rsp_ready=1 -> grants in order 0,1,2,3,0 on consecutive cycles, one result per cycle.
REQ-032 Backpressure: rsp_ready=0 with a full result register for 5 cycles -> req_ready=0 throughout and rsp_data/rsp_id stable; rsp_ready=1 -> drain and new grant in the same cycle.
REQ-033 Pointer: requesters 1 and 3 valid, P=2 -> grant 3, then P=0 -> grant 1.
REQ-034 Reset mid-flow: assert reset while rsp_valid=1 -> next cycle rsp_valid=0 and P=0; first post-reset grant goes to the lowest valid index.
